game_step_engine: RTL
=====================

// Module: game_step_engine
// PURPOSE
//  Parametrised successor of the 2048 move/merge/check logic for an NxN board.
//  It takes one board snapshot and one direction, then shifts and merges the
//  board one line per clock. It also accumulates score, flags whether anything
//  moved, and computes the win/lose verdict. It sits between the input
//  decoder and the tile spawner/display path; spawning new tiles is done elsewhere.
// PARAMETERS
//  N        4   board dimension (lines and cells per line); N >= 2
//  TW       12  tile width; cells hold the tile value (power of two), 0 = empty
//  SCORE_W  20  score accumulator width
// PORTS
//  clk        in   1         system clock
//  rst        in   1         synchronous, active-high reset
//  enable     in   1         1 = FSM advances; 0 = FSM holds every register
//  start      in   1         request one move; sampled only in IDLE with enable=1
//  goal       in   4         win exponent; win when any tile >= (1 << goal)
//  direction  in   4         one-hot: [0] up, [1] down, [2] left, [3] right
//  board_in   in   TW x NxN  [row][col] snapshot; captured on the start edge
//  board_out  out  TW x NxN  resulting board; valid from done, held until next start
//  busy       out  1         1 whenever state != IDLE
//  done       out  1         one-cycle pulse when board_out/moved/wl are valid
//  moved      out  1         1 if board_out != captured board_in
//  score      out  SCORE_W   running score; cleared only by rst
//  wl         out  2         2'b11 while busy; else 2'b10 win, 2'b01 lose, 2'b00 play
// BEHAVIOUR
//  Reset values:
//   - state=IDLE; board_out all 0; busy=0; done=0; moved=0; score=0; wl=2'b00.
//   - Reset mid-operation aborts the move; no partial result is kept.
//  States:
//   - IDLE -(start & enable)-> LINE.
//   - LINE runs N cycles; line index 0..N-1, counter width $clog2(N).
//   - LINE -(index==N-1)-> CHECK -> DONE -> IDLE.
//  Capture:
//   - The start edge registers board_in and direction into a working board.
//   - board_in changes after that edge have no effect.
//  Latency:
//   - Start sampled at edge 0 gives LINE at cycles 1..N, CHECK at N+1, done=1 at N+2.
//   - This holds when enable stays 1. Each cycle with enable=0 adds one cycle.
//  Stall:
//   - With enable=0, state, counter, working board, score and outputs hold.
//   - done stays high if stalled in DONE; it clears on the first enabled cycle.
//  Line processing (one line per LINE cycle):
//   - left/right process rows, up/down process columns.
//   - Order is taken from the leading edge (left: col 0 first, up: row 0 first).
//   - Step 1, compact: remove zeros.
//   - Step 2, merge: scan from the lead; equal adjacent pair becomes one tile of 2x value.
//     Each result tile merges at most once; [2,2,2,2] -> [4,4], not [8].
//   - Step 3: pad the far end with zeros.
//  Overflow:
//   - A pair of value 1 << (TW-1) does not merge; both tiles stay.
//  Score:
//   - score += value of each merged tile, summed per line.
//   - score saturates at all ones and never wraps.
//  moved:
//   - Set if any line's output differs from its input.
//   - Computed incrementally; final at DONE.
//  CHECK:
//   - Win: any tile >= (1 << goal). goal >= TW never wins.
//   - Lose: no zero cell and no equal horizontally/vertically adjacent pair.
//   - Win has priority over lose. Verdict is registered into wl at DONE.
//  DONE:
//   - Loads board_out, moved and wl; pulses done.
//   - board_out updates only here.
//  Invalid direction (not one-hot, including 0):
//   - Same latency; board_out = captured board.
//   - moved=0, score unchanged; wl is still evaluated.
//  start while busy: ignored, no queueing.
//   - start in the same enabled cycle as DONE is also ignored.
//   - It is accepted only in IDLE.
//  Simultaneous rst and start: rst wins.
// TESTING (N=4, TW=12; rows listed top to bottom, "row r = [...]")
//  1. row0=[2,2,4,0], rest 0, left, goal=11
//     -> row0=[4,4,0,0]; moved=1; score=4; wl=00; done exactly 6 cycles after start.
//  2. row0=[2,2,2,2], row1=[2,2,2,0], right
//     -> row0=[0,0,4,4], row1=[0,0,2,4]; score=12.
//     Then column 0 = [4,4,8,0] with up -> column 0 = [8,8,0,0].
//  3. Full checkerboard of 2/4 (no equal neighbours), left
//     -> board unchanged; moved=0; score unchanged; wl=01.
//  4. row0=[1024,1024,0,0], goal=11, left
//     -> row0=[2048,0,0,0]; wl=10; score += 2048.
//     row0=[2048,2048,0,0] -> no merge, moved=0.
//  5. enable=0 for 3 cycles during LINE
//     -> done at cycle 9, same result as unstalled.
//     start pulsed while busy -> no second done.
//     rst at cycle 2 -> next cycle busy=0, board_out=0, score=0, wl=00.
//  6. direction=4'b0011
//     -> done at cycle 6; board_out == board_in; moved=0; score unchanged.

Source files
------------

// File: rtl/game_step_engine.sv
// game_step_engine
//   Shifts and merges an NxN 2048 board in one direction, one line per clock.
//   Accumulates a saturating score, reports whether anything moved, and
//   produces the win/lose verdict for the resulting board.
// Ports
//   clk, rst          system clock, synchronous active-high reset
//   enable            1 = FSM advances, 0 = every register holds
//   start             move request, accepted only in IDLE
//   goal              win exponent (win when any tile >= 1 << goal)
//   direction         one-hot {right, left, down, up}
//   board_in          [row][col] snapshot, captured on the start edge
//   board_out         resulting board, updated only when done pulses
//   busy, done        state != IDLE / one-cycle result strobe
//   moved, score, wl  board changed / running score / verdict (11 = working)
//
// state | meaning
// IDLE  | waiting for start
// LINE  | processing line idx (N cycles)
// CHECK | evaluating win/lose on the working board
// DONE  | results presented, done high
module game_step_engine #(
  parameter int N       = 4,
  parameter int TW      = 12,
  parameter int SCORE_W = 20
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            enable,
  input  logic                            start,
  input  logic [3:0]                      goal,
  input  logic [3:0]                      direction,
  input  logic [N-1:0][N-1:0][TW-1:0]     board_in,
  output logic [N-1:0][N-1:0][TW-1:0]     board_out,
  output logic                            busy,
  output logic                            done,
  output logic                            moved,
  output logic [SCORE_W-1:0]              score,
  output logic [1:0]                      wl
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_LINE  = 2'd1;
  localparam logic [1:0] S_CHECK = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam int             IW   = $clog2(N);
  localparam logic [IW-1:0]  LAST = IW'(N - 1);
  localparam logic [TW-1:0]  MAXV = {1'b1, {(TW-1){1'b0}}};
  // wide enough for score plus one line's worth of merges without wrapping
  localparam int             AW   = ((SCORE_W > TW) ? SCORE_W : TW) + IW + 1;

  logic [1:0]                      state;
  logic [IW-1:0]                   idx;
  logic [3:0]                      dir_q;
  logic                            moved_acc;
  logic [N-1:0][N-1:0][TW-1:0]     work;
  logic [N-1:0][N-1:0][TW-1:0]     work_upd;

  logic [TW-1:0] ln  [N];
  logic [TW-1:0] cmp [N+1];
  logic [TW-1:0] res [N];
  logic [TW-1:0] mv;
  logic [AW-1:0] gain;
  logic [AW-1:0] sum;
  logic [SCORE_W-1:0] score_nxt;
  logic          line_chg;
  logic          dir_ok;
  logic          skip;
  int            cnt;
  int            o;

  assign dir_ok = $onehot(dir_q);
  assign busy   = (state != S_IDLE);

  // Current line, ordered from the leading edge of the move.
  always_comb begin
    for (int k = 0; k < N; k++) begin
      ln[k] = '0;
      case (dir_q)
        4'b0001: ln[k] = work[k][idx];
        4'b0010: ln[k] = work[N-1-k][idx];
        4'b0100: ln[k] = work[idx][k];
        4'b1000: ln[k] = work[idx][N-1-k];
        default: ln[k] = work[idx][k];
      endcase
    end
  end

  // Compact, then merge; cmp[N] is a permanent zero so the pair look-ahead
  // never leaves the array.
  always_comb begin
    for (int j = 0; j <= N; j++) cmp[j] = '0;
    for (int j = 0; j < N; j++) res[j] = '0;
    cnt      = 0;
    o        = 0;
    skip     = 1'b0;
    mv       = '0;
    gain     = '0;
    line_chg = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (ln[k] != '0) begin
        for (int j = 0; j < N; j++)
          if (j == cnt) cmp[j] = ln[k];
        cnt++;
      end
    end
    for (int k = 0; k < N; k++) begin
      if (skip) begin
        skip = 1'b0;
      end else if (cmp[k] != '0) begin
        // the top tile value cannot double within TW bits, so it never merges
        if ((cmp[k] == cmp[k+1]) && (cmp[k] != MAXV)) begin
          mv   = cmp[k] << 1;
          gain = gain + AW'(mv);
          skip = 1'b1;
        end else begin
          mv = cmp[k];
        end
        for (int j = 0; j < N; j++)
          if (j == o) res[j] = mv;
        o++;
      end
    end
    for (int k = 0; k < N; k++)
      if (res[k] != ln[k]) line_chg = 1'b1;
  end

  always_comb begin
    work_upd = work;
    if (dir_ok) begin
      for (int k = 0; k < N; k++) begin
        case (dir_q)
          4'b0001: work_upd[k][idx]     = res[k];
          4'b0010: work_upd[N-1-k][idx] = res[k];
          4'b0100: work_upd[idx][k]     = res[k];
          default: work_upd[idx][N-1-k] = res[k];
        endcase
      end
    end
  end

  always_comb begin
    sum       = AW'(score) + gain;
    score_nxt = (sum > AW'({SCORE_W{1'b1}})) ? {SCORE_W{1'b1}} : sum[SCORE_W-1:0];
  end

  logic          win;
  logic          lose;
  logic          can_move;
  logic [TW-1:0] thr;

  always_comb begin
    thr      = TW'(1) << goal;
    win      = 1'b0;
    can_move = 1'b0;
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) begin
        if ((int'(goal) < TW) && (work[r][c] >= thr)) win = 1'b1;
        if (work[r][c] == '0) can_move = 1'b1;
      end
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N - 1; c++)
        if (work[r][c] == work[r][c+1]) can_move = 1'b1;
    for (int r = 0; r < N - 1; r++)
      for (int c = 0; c < N; c++)
        if (work[r][c] == work[r+1][c]) can_move = 1'b1;
    lose = !can_move;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      idx       <= '0;
      dir_q     <= '0;
      moved_acc <= 1'b0;
      work      <= '0;
      board_out <= '0;
      moved     <= 1'b0;
      score     <= '0;
      wl        <= 2'b00;
      done      <= 1'b0;
    end else if (enable) begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            work      <= board_in;
            dir_q     <= direction;
            idx       <= '0;
            moved_acc <= 1'b0;
            wl        <= 2'b11;
            state     <= S_LINE;
          end
        end
        S_LINE: begin
          work <= work_upd;
          if (dir_ok) begin
            score     <= score_nxt;
            moved_acc <= moved_acc | line_chg;
          end
          if (idx == LAST) state <= S_CHECK;
          else             idx   <= idx + 1'b1;
        end
        S_CHECK: begin
          board_out <= work;
          moved     <= moved_acc;
          wl        <= win ? 2'b10 : (lose ? 2'b01 : 2'b00);
          done      <= 1'b1;
          state     <= S_DONE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
